// File: rtl/pipe_pc_predict_pkg.sv
// rtl/pipe_pc_predict_pkg.sv - Y86-64 icode/ifun constants shared by the next-PC unit
package pipe_pc_predict_pkg;

    localparam logic [3:0] IJXX     = 4'h7;
    localparam logic [3:0] ICALL    = 4'h8;
    localparam logic [3:0] IRET     = 4'h9;
    localparam logic [3:0] IFUN_JMP = 4'h0;

    function automatic logic isCondJump(input logic [3:0] icode, input logic [3:0] ifun);
        return (icode == IJXX) && (ifun != IFUN_JMP);
    endfunction

endpackage

// File: rtl/pipe_pc_predict_ras.sv
// rtl/pipe_pc_predict_ras.sv - circular return address stack; overflow overwrites the oldest entry
module pipe_ras #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushData,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [CNT_W-1:0]  count;

    // sp points at the next free slot, so the top lives one below it
    assign top   = mem[sp - 1'b1];
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            mem[sp] <= pushData;
            sp      <= sp + 1'b1;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            sp    <= sp - 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_pc_predict.sv
// rtl/pipe_pc_predict.sv - fetch PC register with PHT jXX prediction and redirects; PIPE_RAS_EN adds ret prediction
module pipe_pc_predict
    import pipe_pc_predict_pkg::*;
#(
    parameter int ADDR_W            = 64,
    parameter int PHT_ENTRIES       = 16,
    parameter int CTR_W             = 2,
    parameter int RAS_DEPTH         = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_stall,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    output logic [ADDR_W-1:0] f_pc,
    output logic              f_pred_taken,
    output logic [ADDR_W-1:0] f_ret_pred,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic              res_taken,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic [ADDR_W-1:0] res_fallthru,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] ret_valM,
    input  logic [ADDR_W-1:0] ret_pred,
    output logic              mispredict
);

    localparam int IDX_W = $clog2(PHT_ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [CTR_W-1:0]  pht [PHT_ENTRIES];
    logic [IDX_W-1:0]  fIdx;
    logic [IDX_W-1:0]  resIdx;
    logic              jxxMiss;
    logic              retRedirect;
    logic [ADDR_W-1:0] nextPc;
    logic              unusedBits;

    assign fIdx    = f_pc[IDX_W-1:0];
    assign resIdx  = res_pc[IDX_W-1:0];
    assign jxxMiss = res_valid && (res_taken != res_pred_taken);

`ifdef PIPE_RAS_EN
    logic              rasPush;
    logic              rasPop;
    logic [ADDR_W-1:0] rasTop;
    logic              rasEmpty;

    assign retRedirect = ret_valid && (ret_valM != ret_pred);
    assign rasPush     = !f_stall && !mispredict && (f_icode == ICALL);
    assign rasPop      = !f_stall && !mispredict && (f_icode == IRET);
    assign f_ret_pred  = rasEmpty ? f_valP : rasTop;
    assign unusedBits  = ^res_pc[ADDR_W-1:IDX_W];

    pipe_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (rasPush),
        .pop      (rasPop),
        .pushData (f_valP),
        .top      (rasTop),
        .empty    (rasEmpty)
    );
`else
    assign retRedirect = ret_valid;
    assign f_ret_pred  = '0;
    assign unusedBits  = ^{res_pc[ADDR_W-1:IDX_W], ret_pred};
`endif

    assign mispredict = jxxMiss || retRedirect;

    always_comb begin
        f_pred_taken = 1'b0;
        if (isCondJump(f_icode, f_ifun)) begin
            f_pred_taken = pht[fIdx][CTR_W-1];
        end else if (f_icode == IJXX || f_icode == ICALL) begin
            f_pred_taken = 1'b1;
        end
    end

    always_comb begin
        nextPc = f_pc;
        if (jxxMiss) begin
            nextPc = res_taken ? res_target : res_fallthru;
        end else if (retRedirect) begin
            nextPc = ret_valM;
        end else if (!f_stall) begin
            case (f_icode)
                IJXX, ICALL: nextPc = f_pred_taken ? f_valC : f_valP;
`ifdef PIPE_RAS_EN
                IRET:        nextPc = f_ret_pred;
`else
                IRET:        nextPc = f_pc;
`endif
                default:     nextPc = f_valP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc <= RESET_PC;
        end else begin
            f_pc <= nextPc;
        end
    end

    // Training ignores stall and redirect: every resolved jXX counts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (res_valid) begin
            if (res_taken) begin
                if (pht[resIdx] != CTR_MAX) begin
                    pht[resIdx] <= pht[resIdx] + 1'b1;
                end
            end else if (pht[resIdx] != '0) begin
                pht[resIdx] <= pht[resIdx] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_pc_predict.sv
// tb/tb_pipe_pc_predict.sv - directed bench for pipe_pc_predict
module tb_pipe_pc_predict;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_stall;
    logic [3:0]    f_icode;
    logic [3:0]    f_ifun;
    logic [AW-1:0] f_valC;
    logic [AW-1:0] f_valP;
    logic [AW-1:0] f_pc;
    logic          f_pred_taken;
    logic [AW-1:0] f_ret_pred;
    logic          res_valid;
    logic [AW-1:0] res_pc;
    logic          res_taken;
    logic          res_pred_taken;
    logic [AW-1:0] res_target;
    logic [AW-1:0] res_fallthru;
    logic          ret_valid;
    logic [AW-1:0] ret_valM;
    logic [AW-1:0] ret_pred;
    logic          mispredict;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_pc_predict #(
        .ADDR_W      (AW),
        .PHT_ENTRIES (16),
        .CTR_W       (2),
        .RAS_DEPTH   (2),
        .RESET_PC    ('0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .f_stall        (f_stall),
        .f_icode        (f_icode),
        .f_ifun         (f_ifun),
        .f_valC         (f_valC),
        .f_valP         (f_valP),
        .f_pc           (f_pc),
        .f_pred_taken   (f_pred_taken),
        .f_ret_pred     (f_ret_pred),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_pred_taken (res_pred_taken),
        .res_target     (res_target),
        .res_fallthru   (res_fallthru),
        .ret_valid      (ret_valid),
        .ret_valM       (ret_valM),
        .ret_pred       (ret_pred),
        .mispredict     (mispredict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_stall = 0; f_icode = 4'h1; f_ifun = 0; f_valC = 0; f_valP = 0;
        res_valid = 0; res_pc = 0; res_taken = 0; res_pred_taken = 0;
        res_target = 0; res_fallthru = 0;
        ret_valid = 0; ret_valM = 0; ret_pred = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        f_icode = 4'h7; f_ifun = 4'h1;
        #1;
        checks++; if (f_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", f_pc); end
        checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL reset_pht_weak_taken got=%b exp=1", f_pred_taken); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
        f_icode = 4'h1; f_ifun = 0; f_valP = 64'h2;
        #1;
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL nop_pred got=%b exp=0", f_pred_taken); end
        tick();
        checks++; if (f_pc !== 64'h2) begin errors++; $display("FAIL idle_advance got=%h exp=2", f_pc); end
    endtask

    task automatic test_pht_saturate();
        idle_inputs();
        f_valP = 64'h10;
        tick();
        checks++; if (f_pc !== 64'h10) begin errors++; $display("FAIL goto_10 got=%h exp=10", f_pc); end
        f_stall = 1; f_icode = 4'h7; f_ifun = 4'h1; f_valC = 64'h50; f_valP = 64'h19;
        res_valid = 1; res_pc = 64'h10; res_taken = 0; res_pred_taken = 0;
        #1;
        checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL pred_sees_old got=%b exp=1", f_pred_taken); end
        tick();
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL ctr1_pred got=%b exp=0", f_pred_taken); end
        tick();
        tick();
        res_valid = 0;
        #1;
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_sat0_pred got=%b exp=0", f_pred_taken); end
        checks++; if (f_pc !== 64'h10) begin errors++; $display("FAIL stall_hold got=%h exp=10", f_pc); end
        // counter at 0 if saturated; two increments must reach 2 (weakly taken)
        res_valid = 1; res_taken = 1; res_pred_taken = 1;
        tick();
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_inc1_pred got=%b exp=0", f_pred_taken); end
        tick();
        res_valid = 0;
        #1;
        checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_inc2_pred got=%b exp=1", f_pred_taken); end
        f_stall = 0;
        tick();
        checks++; if (f_pc !== 64'h50) begin errors++; $display("FAIL jxx_taken_target got=%h exp=50", f_pc); end
    endtask

    task automatic test_predict_targets();
        idle_inputs();
        f_icode = 4'h8; f_valC = 64'h100; f_valP = 64'h59;
        #1;
        checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL call_pred got=%b exp=1", f_pred_taken); end
        tick();
        checks++; if (f_pc !== 64'h100) begin errors++; $display("FAIL call_target got=%h exp=100", f_pc); end
        f_icode = 4'h7; f_ifun = 4'h0; f_valC = 64'h180; f_valP = 64'h109;
        #1;
        checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL jmp_pred got=%b exp=1", f_pred_taken); end
        tick();
        checks++; if (f_pc !== 64'h180) begin errors++; $display("FAIL jmp_target got=%h exp=180", f_pc); end
        f_icode = 4'h6; f_ifun = 0; f_valC = 64'h999; f_valP = 64'h18a;
        #1;
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL opq_pred got=%b exp=0", f_pred_taken); end
        tick();
        checks++; if (f_pc !== 64'h18a) begin errors++; $display("FAIL opq_next got=%h exp=18a", f_pc); end
    endtask

    task automatic test_redirect_beats_stall();
        idle_inputs();
        f_stall = 1;
        res_valid = 1; res_pc = 64'h21; res_pred_taken = 1; res_taken = 0;
        res_fallthru = 64'h29; res_target = 64'h99;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL miss_flag got=%b exp=1", mispredict); end
        tick();
        checks++; if (f_pc !== 64'h29) begin errors++; $display("FAIL miss_over_stall got=%h exp=29", f_pc); end
        res_valid = 0;
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL miss_clear got=%b exp=0", mispredict); end
    endtask

    task automatic test_miss_vs_ret();
        idle_inputs();
        res_valid = 1; res_pc = 64'h33; res_pred_taken = 0; res_taken = 1;
        res_target = 64'h40; res_fallthru = 64'h3b;
        ret_valid = 1; ret_valM = 64'h80; ret_pred = 64'h0;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL miss_ret_flag got=%b exp=1", mispredict); end
        tick();
        checks++; if (f_pc !== 64'h40) begin errors++; $display("FAIL miss_beats_ret got=%h exp=40", f_pc); end
    endtask

`ifndef PIPE_RAS_EN
    task automatic test_ret_no_ras();
        idle_inputs();
        f_icode = 4'h9; f_valP = 64'h41;
        #1;
        checks++; if (f_ret_pred !== 64'h0) begin errors++; $display("FAIL ret_pred_zero got=%h exp=0", f_ret_pred); end
        tick();
        checks++; if (f_pc !== 64'h40) begin errors++; $display("FAIL ret_hold1 got=%h exp=40", f_pc); end
        tick();
        checks++; if (f_pc !== 64'h40) begin errors++; $display("FAIL ret_hold2 got=%h exp=40", f_pc); end
        f_stall = 1; ret_valid = 1; ret_valM = 64'h77;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL ret_redirect_flag got=%b exp=1", mispredict); end
        tick();
        checks++; if (f_pc !== 64'h77) begin errors++; $display("FAIL ret_redirect got=%h exp=77", f_pc); end
    endtask
`else
    task automatic test_ras();
        idle_inputs();
        f_icode = 4'h8; f_valC = 64'h200; f_valP = 64'h10;
        tick();
        f_valP = 64'h20;
        tick();
        f_valP = 64'h30;
        tick();
        checks++; if (f_pc !== 64'h200) begin errors++; $display("FAIL ras_call_pc got=%h exp=200", f_pc); end
        f_icode = 4'h9; f_valC = 0; f_valP = 64'h99;
        #1;
        checks++; if (f_ret_pred !== 64'h30) begin errors++; $display("FAIL ras_top0 got=%h exp=30", f_ret_pred); end
        tick();
        checks++; if (f_pc !== 64'h30) begin errors++; $display("FAIL ras_ret_pc got=%h exp=30", f_pc); end
        checks++; if (f_ret_pred !== 64'h20) begin errors++; $display("FAIL ras_top1 got=%h exp=20", f_ret_pred); end
        tick();
        checks++; if (f_ret_pred !== 64'h99) begin errors++; $display("FAIL ras_empty got=%h exp=99", f_ret_pred); end
        f_stall = 1; ret_valid = 1; ret_valM = 64'h10; ret_pred = 64'h20;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL ras_wrong_flag got=%b exp=1", mispredict); end
        tick();
        checks++; if (f_pc !== 64'h10) begin errors++; $display("FAIL ras_wrong_redirect got=%h exp=10", f_pc); end
        ret_valM = 64'h10; ret_pred = 64'h10;
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL ras_right_flag got=%b exp=0", mispredict); end
    endtask
`endif

    task automatic test_reset_mid_op();
        idle_inputs();
        f_stall = 1;
        res_valid = 1; res_pc = 64'h10; res_taken = 0; res_pred_taken = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0; res_valid = 0; f_stall = 0;
        f_icode = 4'h7; f_ifun = 4'h2;
        #1;
        checks++; if (f_pc !== 64'h0) begin errors++; $display("FAIL midop_reset_pc got=%h exp=0", f_pc); end
        checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL midop_pht_cleared got=%b exp=1", f_pred_taken); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_pht_saturate();
        test_predict_targets();
        test_redirect_beats_stall();
        test_miss_vs_ret();
`ifndef PIPE_RAS_EN
        test_ret_no_ras();
`else
        test_ras();
`endif
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
